// File: rtl/hazard_scoreboard.sv
// Interlock/forwarding scoreboard tracking in-flight destinations across DEPTH post-ID slots.
// Optional HAZARD_PERF_CNT_EN adds the stall_cycles and fwd_events counters.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 3,
    localparam int unsigned REG_AW    = $clog2(NUM_REGS),
    localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush_id,
    output logic              stall,
    output logic [SEL_W-1:0]  ex_fwd_a,
    output logic [SEL_W-1:0]  ex_fwd_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       fwd_events
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } slot_t;

    slot_t            slots [DEPTH];
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             haz_a;
    logic             haz_b;
    logic             issue;
    logic [SEL_W-1:0] nxt_fwd_a;
    logic [SEL_W-1:0] nxt_fwd_b;

    function automatic int ready_of(input logic is_load);
        return is_load ? int'(LOAD_READY) : 2;
    endfunction

    // Producer search: scan oldest to youngest so the youngest candidate wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int s = int'(DEPTH) - 1; s >= 1; s--) begin
            if (slots[s-1].valid && slots[s-1].dest != '0) begin
                if (id_rs_used && id_rs != '0 && slots[s-1].dest == id_rs) begin
                    sel_a = SEL_W'(s + 1);
                    haz_a = (s + 1) < ready_of(slots[s-1].is_load);
                end
                if (id_rt_used && id_rt != '0 && slots[s-1].dest == id_rt) begin
                    sel_b = SEL_W'(s + 1);
                    haz_b = (s + 1) < ready_of(slots[s-1].is_load);
                end
            end
        end
    end

    assign stall     = id_valid && !flush_id && (haz_a || haz_b);
    assign issue     = id_valid && !flush_id && !stall;
    assign nxt_fwd_a = issue ? sel_a : '0;
    assign nxt_fwd_b = issue ? sel_b : '0;

    // Slot shift register and registered forward selects.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots[i] <= '0;
            end
            ex_fwd_a <= '0;
            ex_fwd_b <= '0;
        end else begin
            if (issue) begin
                slots[0] <= '{valid: id_wr_en && (id_rd != '0), dest: id_rd, is_load: id_is_load};
            end else begin
                slots[0] <= '0;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                slots[i] <= slots[i-1];
            end
            ex_fwd_a <= nxt_fwd_a;
            ex_fwd_b <= nxt_fwd_b;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(stall);
            fwd_events   <= fwd_events + 32'(nxt_fwd_a != '0) + 32'(nxt_fwd_b != '0);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default instance and a DEPTH=5/LOAD_READY=4 instance share inputs.
// Each instance is checked every cycle against a timestamp-based model plus directed literals.
module tb_hazard_scoreboard;

    localparam int unsigned AW = 5;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [AW-1:0] id_rd;
    logic          id_wr_en;
    logic          id_is_load;
    logic          flush_id;
    logic          stall0;
    logic          stall1;
    logic [1:0]    fwd0_a;
    logic [1:0]    fwd0_b;
    logic [2:0]    fwd1_a;
    logic [2:0]    fwd1_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   sc0;
    logic [31:0]   fe0;
    logic [31:0]   sc1;
    logic [31:0]   fe1;
`endif

    hazard_scoreboard #(.NUM_REGS(32), .DEPTH(3), .LOAD_READY(3)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .id_is_load(id_is_load), .flush_id(flush_id), .stall(stall0),
        .ex_fwd_a(fwd0_a), .ex_fwd_b(fwd0_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc0), .fwd_events(fe0)
`endif
    );

    hazard_scoreboard #(.NUM_REGS(32), .DEPTH(5), .LOAD_READY(4)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .id_is_load(id_is_load), .flush_id(flush_id), .stall(stall1),
        .ex_fwd_a(fwd1_a), .ex_fwd_b(fwd1_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1), .fwd_events(fe1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: every issued writer is remembered with the cycle it entered EX.
    typedef struct {
        int            t;
        logic [AW-1:0] rd;
        logic          ld;
    } rec_t;

    rec_t  q0[$];
    rec_t  q1[$];
    int    cyc;
    bit    model_ok;
    int    checks;
    int    failures;
    logic  m_stall0, m_stall1, m_iss0, m_iss1;
    int    pend0_a, pend0_b, pend1_a, pend1_b;
    int    exp0_a, exp0_b, exp1_a, exp1_b;
    logic [31:0] esc0, efe0, esc1, efe1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input rec_t q[$], input int now, input int depth, input int lr,
                                   input logic [AW-1:0] x, input logic used,
                                   output int sel, output logic haz);
        int best;
        best = -1;
        sel  = 0;
        haz  = 1'b0;
        if (used && x != '0) begin
            foreach (q[i]) begin
                int age;
                age = now - q[i].t;
                if (age >= 1 && age < depth && q[i].rd == x && q[i].t > best) begin
                    best = q[i].t;
                    sel  = age + 1;
                    haz  = (age + 1) < (q[i].ld ? lr : 2);
                end
            end
        end
    endfunction

    function automatic void eval_cfg(input rec_t q[$], input int depth, input int lr,
                                     output logic st, output logic iss, output int pa, output int pb);
        int   sa, sb;
        logic ha, hb;
        lookup(q, cyc, depth, lr, id_rs, id_rs_used, sa, ha);
        lookup(q, cyc, depth, lr, id_rt, id_rt_used, sb, hb);
        st  = id_valid && !flush_id && (ha || hb);
        iss = id_valid && !flush_id && !st;
        pa  = iss ? sa : 0;
        pb  = iss ? sb : 0;
    endfunction

    // Compare process: inputs are stable at the falling edge.
    always @(negedge clk) begin
        eval_cfg(q0, 3, 3, m_stall0, m_iss0, pend0_a, pend0_b);
        eval_cfg(q1, 5, 4, m_stall1, m_iss1, pend1_a, pend1_b);
        if (model_ok) begin
            chk("m_stall0", int'(stall0), int'(m_stall0));
            chk("m_fwd0_a", int'(fwd0_a), exp0_a);
            chk("m_fwd0_b", int'(fwd0_b), exp0_b);
            chk("m_stall1", int'(stall1), int'(m_stall1));
            chk("m_fwd1_a", int'(fwd1_a), exp1_a);
            chk("m_fwd1_b", int'(fwd1_b), exp1_b);
`ifdef HAZARD_PERF_CNT_EN
            chk("m_sc0", int'(sc0), int'(esc0));
            chk("m_fe0", int'(fe0), int'(efe0));
            chk("m_sc1", int'(sc1), int'(esc1));
            chk("m_fe1", int'(fe1), int'(efe1));
`endif
        end
    end

    // Model state update at the active edge.
    always @(posedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            exp0_a = 0; exp0_b = 0; exp1_a = 0; exp1_b = 0;
            esc0 = '0; efe0 = '0; esc1 = '0; efe1 = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (m_iss0 && id_wr_en && id_rd != '0) q0.push_back('{t: cyc, rd: id_rd, ld: id_is_load});
            if (m_iss1 && id_wr_en && id_rd != '0) q1.push_back('{t: cyc, rd: id_rd, ld: id_is_load});
            exp0_a = pend0_a; exp0_b = pend0_b;
            exp1_a = pend1_a; exp1_b = pend1_b;
            esc0 = esc0 + 32'(m_stall0);
            esc1 = esc1 + 32'(m_stall1);
            efe0 = efe0 + 32'(pend0_a != 0) + 32'(pend0_b != 0);
            efe1 = efe1 + 32'(pend1_a != 0) + 32'(pend1_b != 0);
        end
        cyc++;
        while (q0.size() > 0 && cyc - q0[0].t > 8) void'(q0.pop_front());
        while (q1.size() > 0 && cyc - q1[0].t > 8) void'(q1.pop_front());
    end

    // Present one ID instruction, holding it while the followed instance stalls.
    task automatic instr(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic ru, input logic tu, input logic [AW-1:0] rd,
                         input logic we, input logic ld, input logic fl, input int follow,
                         output int nst);
        logic st;
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
        id_rd = rd; id_wr_en = we; id_is_load = ld; flush_id = fl;
        nst = 0;
        for (int k = 0; k < 10; k++) begin
            #3;
            st = (follow == 0) ? stall0 : stall1;
            @(posedge clk);
            #1;
            if (!st) return;
            nst++;
        end
        chk("issue_bound", 1, 0);
    endtask

    task automatic nop(input int n);
        int d;
        for (int k = 0; k < n; k++) instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, d);
    endtask

    task automatic pulse_reset();
        id_valid = 0; flush_id = 0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; model_ok = 0; cyc = 0;
        reset = 1; id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
        id_rd = '0; id_wr_en = 0; id_is_load = 0; flush_id = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_stall", int'(stall0), 0);
        chk("rst_fwd_a", int'(fwd0_a), 0);
        chk("rst_fwd_b", int'(fwd0_b), 0);

        // ALU -> ALU back to back
        nop(4);
        instr(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, n);
        instr(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, n);
        chk("alu_stall", n, 0);
        chk("alu_fwd_a", int'(fwd0_a), 2);
        chk("alu_fwd_b", int'(fwd0_b), 0);

        // Load-use: one stall cycle, then forward from slot 3
        nop(4);
        instr(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, n);
        instr(1, 5, 2, 1, 1, 4, 1, 0, 0, 0, n);
        chk("lu_stall_len", n, 1);
        chk("lu_fwd_b", int'(fwd0_b), 3);
        chk("lu_fwd_a", int'(fwd0_a), 0);

        // Load-use at distance 2
        nop(4);
        instr(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, n);
        nop(1);
        instr(1, 2, 2, 1, 1, 4, 1, 0, 0, 0, n);
        chk("ld2_stall", n, 0);
        chk("ld2_fwd_a", int'(fwd0_a), 3);
        chk("ld2_fwd_b", int'(fwd0_b), 3);

        // Youngest producer wins; r0 never matches
        nop(4);
        instr(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, n);
        instr(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, n);
        instr(1, 1, 0, 1, 1, 5, 1, 0, 0, 0, n);
        chk("young_fwd_a", int'(fwd0_a), 2);
        chk("young_fwd_b", int'(fwd0_b), 0);
        instr(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, n);
        instr(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, n);
        chk("r0_stall", n, 0);
        chk("r0_fwd_a", int'(fwd0_a), 0);
        chk("r0_fwd_b", int'(fwd0_b), 0);

        // Slot DEPTH-1 forwards; slot DEPTH is left to the register file
        nop(4);
        instr(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, n);
        nop(1);
        instr(1, 1, 0, 1, 0, 8, 1, 0, 0, 0, n);
        chk("far_fwd_a", int'(fwd0_a), 3);
        nop(4);
        instr(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, n);
        nop(2);
        instr(1, 1, 0, 1, 0, 8, 1, 0, 0, 0, n);
        chk("wb_fwd0_a", int'(fwd0_a), 0);
        chk("wb_fwd1_a", int'(fwd1_a), 4);

        // Flush beats stall and leaves a bubble
        nop(4);
        instr(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, n);
        instr(1, 5, 2, 1, 1, 4, 1, 0, 1, 0, n);
        chk("flush_stall", n, 0);
        chk("flush_fwd_b", int'(fwd0_b), 0);
        instr(1, 4, 0, 1, 0, 8, 1, 0, 0, 0, n);
        chk("flush_bubble", int'(fwd0_a), 0);

        // Reset while a load sits in slot 1
        nop(4);
        instr(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, n);
        pulse_reset();
        instr(1, 5, 2, 1, 1, 4, 1, 0, 0, 0, n);
        chk("rst_mid_stall", n, 0);
        chk("rst_mid_fwd_b", int'(fwd0_b), 0);

        // DEPTH=5, LOAD_READY=4: two stall cycles, forward from slot 4
        pulse_reset();
        instr(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, n);
        instr(1, 7, 0, 1, 0, 9, 1, 0, 0, 1, n);
        chk("gen_stall_len", n, 2);
        chk("gen_fwd_a", int'(fwd1_a), 4);
`ifdef HAZARD_PERF_CNT_EN
        chk("gen_stall_cycles", int'(sc1), 2);
        chk("gen_fwd_events", int'(fe1), 1);
`endif
        nop(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
